reorder_buffer: RTL

In-order retirement buffer downstream of the rename stage, and the producer of rename's free-list writeback and branch-recovery inputs. Allocates one entry per renamed instruction and marks entries done on functional-unit completion. Retires from the head in program order, returning pd_old to the free list. On branch resolution it issues hit/mispredict with the branch's ROB tag and flushes all younger entries.

---
 rtl/reorder_buffer_if.sv | 55 +++++
 rtl/reorder_buffer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// -----------------------------------------------------------------------------
// reorder_buffer_if
// Bundles every reorder_buffer signal except clk/reset.
//   master : rename/execute side, drives allocation, completion and
//            branch-resolution inputs, receives commit/free/recovery outputs.
//   slave  : the reorder buffer itself.
// Signal groups:
//   allocation : valid_in, ready_in, in_pc, in_rob_tag, in_pd_new, in_pd_old,
//                in_is_branch
//   completion : cmp_valid[NUM_CMP], cmp_tag[NUM_CMP*4]
//   resolution : br_valid, br_tag, br_mispredict
//   retirement : write_en, rob_data_out, commit_valid, commit_pc
//   recovery   : mispredict, mispredict_tag, hit
//   status     : empty, tag_err
// -----------------------------------------------------------------------------
interface reorder_buffer_if #(
   parameter int NUM_CMP = 3,
   parameter int PREG_W  = 7
);
   logic                 valid_in;
   logic                 ready_in;
   logic [31:0]          in_pc;
   logic [3:0]           in_rob_tag;
   logic [PREG_W-1:0]    in_pd_new;
   logic [PREG_W-1:0]    in_pd_old;
   logic                 in_is_branch;
   logic [NUM_CMP-1:0]   cmp_valid;
   logic [NUM_CMP*4-1:0] cmp_tag;
   logic                 br_valid;
   logic [3:0]           br_tag;
   logic                 br_mispredict;
   logic                 write_en;
   logic [PREG_W-1:0]    rob_data_out;
   logic                 mispredict;
   logic [4:0]           mispredict_tag;
   logic                 hit;
   logic                 commit_valid;
   logic [31:0]          commit_pc;
   logic                 empty;
   logic                 tag_err;

   modport master (
      output valid_in, in_pc, in_rob_tag, in_pd_new, in_pd_old, in_is_branch,
             cmp_valid, cmp_tag, br_valid, br_tag, br_mispredict,
      input  ready_in, write_en, rob_data_out, mispredict, mispredict_tag, hit,
             commit_valid, commit_pc, empty, tag_err
   );

   modport slave (
      input  valid_in, in_pc, in_rob_tag, in_pd_new, in_pd_old, in_is_branch,
             cmp_valid, cmp_tag, br_valid, br_tag, br_mispredict,
      output ready_in, write_en, rob_data_out, mispredict, mispredict_tag, hit,
             commit_valid, commit_pc, empty, tag_err
   );
endinterface

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// In-order retirement buffer behind the rename stage. Allocates one entry per
// renamed instruction at tail, marks entries done on completion, retires one
// done entry per cycle from head (returning pd_old to rename's free list), and
// turns branch resolutions into one-cycle hit/mispredict pulses, flushing all
// entries younger than a mispredicted branch.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-low
//   bus    : reorder_buffer_if.slave (allocation, completion, resolution,
//            retirement, recovery and status signals)
//
// Build option:
//   ROB_TAG_CHECK_EN : when defined, every allocation compares in_rob_tag with
//                      tail and sets a sticky tag_err on mismatch. When left
//                      undefined, tag_err is tied to 0.
// -----------------------------------------------------------------------------
module reorder_buffer #(
   parameter int DEPTH   = 16,
   parameter int NUM_CMP = 3,
   parameter int PREG_W  = 7
) (
   input logic             clk,
   input logic             reset,
   reorder_buffer_if.slave bus
);
   localparam int              TAG_W    = $clog2(DEPTH);
   localparam logic [TAG_W:0]  FULL_CNT = (TAG_W+1)'(DEPTH);

   logic [DEPTH-1:0]   ent_valid, ent_done;
   logic [DEPTH-1:0]   valid_nxt, done_nxt;
   logic [31:0]        ent_pc     [DEPTH];
   logic [PREG_W-1:0]  ent_pd_new [DEPTH];
   logic [PREG_W-1:0]  ent_pd_old [DEPTH];
   logic [TAG_W-1:0]   head, tail, tail_nxt, br_age;
   logic [TAG_W:0]     count, count_nxt;
   logic               alloc, do_commit, flush, has_dest;

   // A mispredict blocks allocation so rename can redirect before new entries
   // land behind the restored tail.
   assign flush        = bus.br_valid && bus.br_mispredict;
   assign bus.ready_in = (count != FULL_CNT) && !flush;
   assign bus.empty    = (count == '0);
   assign alloc        = bus.valid_in && bus.ready_in;
   assign do_commit    = ent_valid[head] && ent_done[head];
   assign has_dest     = (ent_pd_new[head] != '0);
   // Age of the branch relative to head; anything older-than-or-equal survives.
   assign br_age       = bus.br_tag - head;

   // NOTE: every variable gets a default at the top of the block so no path
   // leaves it unassigned; that is what keeps this logic free of latches.
   always_comb begin
      valid_nxt = ent_valid;
      done_nxt  = ent_done;
      for (int p = 0; p < NUM_CMP; p++) begin
         if (bus.cmp_valid[p] && ent_valid[bus.cmp_tag[p*TAG_W +: TAG_W]])
            done_nxt[bus.cmp_tag[p*TAG_W +: TAG_W]] = 1'b1;
      end
      if (bus.br_valid && ent_valid[bus.br_tag])
         done_nxt[bus.br_tag] = 1'b1;
      // Flush is applied after completions so a completion to a flushed tag
      // loses. Age is measured from head, which also handles a full buffer.
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (TAG_W'(TAG_W'(i) - head) > br_age)
               valid_nxt[i] = 1'b0;
         end
      end
      // Head is never younger than the branch, so commit and flush don't clash.
      if (do_commit)
         valid_nxt[head] = 1'b0;
      if (alloc) begin
         valid_nxt[tail] = 1'b1;
         done_nxt[tail]  = 1'b0;
      end
   end

   always_comb begin
      if (flush) begin
         tail_nxt  = bus.br_tag + TAG_W'(1);
         count_nxt = (TAG_W+1)'(br_age) + (TAG_W+1)'(1) - (TAG_W+1)'(do_commit);
      end else begin
         tail_nxt  = tail + TAG_W'(alloc);
         count_nxt = count + (TAG_W+1)'(alloc) - (TAG_W+1)'(do_commit);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ent_valid          <= '0;
         ent_done           <= '0;
         head               <= '0;
         tail               <= '0;
         count              <= '0;
         bus.commit_valid   <= 1'b0;
         bus.commit_pc      <= '0;
         bus.write_en       <= 1'b0;
         bus.rob_data_out   <= '0;
         bus.hit            <= 1'b0;
         bus.mispredict     <= 1'b0;
         bus.mispredict_tag <= '0;
      end else begin
         ent_valid          <= valid_nxt;
         ent_done           <= done_nxt;
         head               <= head + TAG_W'(do_commit);
         tail               <= tail_nxt;
         count              <= count_nxt;
         bus.commit_valid   <= do_commit;
         bus.write_en       <= do_commit && has_dest;
         if (do_commit)
            bus.commit_pc <= ent_pc[head];
         if (do_commit && has_dest)
            bus.rob_data_out <= ent_pd_old[head];
         bus.hit            <= bus.br_valid && !bus.br_mispredict;
         bus.mispredict     <= flush;
         bus.mispredict_tag <= bus.br_valid ? {1'b0, bus.br_tag} : 5'd0;
      end
   end

   // NOTE: the payload array has no reset; an entry's fields are only read
   // while its valid bit (which is reset) says they were written.
   always_ff @(posedge clk) begin
      if (alloc) begin
         ent_pc[tail]     <= bus.in_pc;
         ent_pd_new[tail] <= bus.in_pd_new;
         ent_pd_old[tail] <= bus.in_pd_old;
      end
   end

`ifdef ROB_TAG_CHECK_EN
   always_ff @(posedge clk) begin
      if (!reset)
         bus.tag_err <= 1'b0;
      else if (alloc && (bus.in_rob_tag != tail))
         bus.tag_err <= 1'b1;
   end
`else
   assign bus.tag_err = 1'b0;
`endif

endmodule
